// File: rtl/sram_responder_16x8.sv
// Purpose: 16x8 SRAM responder behind an active-low ce_n/we_n/oe_n strobe interface.
// Latency: writes commit on the trailing strobe edge; read data valid READ_LAT edges after the read strobe is first sampled.
// Backpressure: none; the controller paces accesses via strobes, and illegal strobe mixes park the FSM in ERROR.
module sram_responder_16x8 #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1   // legal range 1..4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce_n,
  input  logic              we_n,
  input  logic              oe_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              err,
  output logic [7:0]        acc_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  // Two bits cover a reload value of READ_LAT-1 for latencies up to 4.
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WRITE      = 3'd1,
    S_READ_WAIT  = 3'd2,
    S_READ_DRIVE = 3'd3,
    S_ERROR      = 3'd4
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rdata_valid_q;
  logic                busy_q;
  logic                err_q;
  logic [7:0]          acc_cnt_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Active-high views of the strobes and the derived access classes.
  logic sel;
  logic wr_stb;
  logic rd_stb;
  logic wr_only;
  logic rd_only;
  logic conflict;
  logic addr_hit;

  // Decode the raw strobes once so the FSM reads in terms of access kinds.
  always_comb begin
    sel      = ~ce_n;
    wr_stb   = ~we_n;
    rd_stb   = ~oe_n;
    wr_only  = sel & wr_stb & ~rd_stb;
    rd_only  = sel & rd_stb & ~wr_stb;
    conflict = sel & wr_stb & rd_stb;
    addr_hit = (addr == addr_q);
  end

  // Access FSM: owns the array, latched address/data, the latency counter and every output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      acc_cnt_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          rdata_q       <= '0;
          rdata_valid_q <= 1'b0;
          if (conflict) begin
            state_q <= S_ERROR;
            busy_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (wr_only) begin
            state_q <= S_WRITE;
            busy_q  <= 1'b1;
            addr_q  <= addr;
            wdata_q <= wdata;
          end else if (rd_only) begin
            state_q <= S_READ_WAIT;
            busy_q  <= 1'b1;
            addr_q  <= addr;
            cnt_q   <= CNT_LOAD;
          end else begin
            busy_q  <= 1'b0;
          end
        end

        S_WRITE: begin
          if (sel && wr_stb) begin
            if (rd_stb) begin
              // Output enable during a write is illegal; the pending data is dropped.
              state_q <= S_ERROR;
              err_q   <= 1'b1;
            end else begin
              // Address is frozen at entry; data follows the bus until the trailing edge.
              wdata_q <= wdata;
            end
          end else begin
            mem_q[addr_q] <= wdata_q;
            acc_cnt_q     <= acc_cnt_q + 8'd1;
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
          end
        end

        S_READ_WAIT: begin
          if (!sel || !rd_stb) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (wr_stb) begin
            state_q <= S_ERROR;
            err_q   <= 1'b1;
          end else if (cnt_q == '0) begin
            state_q       <= S_READ_DRIVE;
            rdata_q       <= mem_q[addr_q];
            rdata_valid_q <= 1'b1;
            acc_cnt_q     <= acc_cnt_q + 8'd1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_READ_DRIVE: begin
          if (!sel || !rd_stb) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
          end else if (wr_stb) begin
            state_q       <= S_ERROR;
            err_q         <= 1'b1;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
          end else if (!addr_hit) begin
            // A new address under a held read strobe restarts the latency count.
            state_q       <= S_READ_WAIT;
            addr_q        <= addr;
            cnt_q         <= CNT_LOAD;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
          end
        end

        S_ERROR: begin
          rdata_q       <= '0;
          rdata_valid_q <= 1'b0;
          if (!sel) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q       <= S_IDLE;
          busy_q        <= 1'b0;
          rdata_q       <= '0;
          rdata_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign acc_cnt     = acc_cnt_q;

endmodule

// File: tb/tb_sram_responder_16x8.sv
// Purpose: randomized scenario bench for sram_responder_16x8 at READ_LAT 1 and 3 side by side.
// Latency: both instances share the strobes; expected timing is derived per instance from its latency.
// Backpressure: none; the bench paces every access in fixed cycle counts.
module tb_sram_responder_16x8;

  logic       clk;
  logic       rst_n;
  logic       ce_n;
  logic       we_n;
  logic       oe_n;
  logic [3:0] addr;
  logic [7:0] wdata;

  logic [7:0] rd1, rd3, ac1, ac3;
  logic       v1, v3, b1, b3, e1, e3;

  // Reference model: plain array of words and a count of completed accesses.
  logic [7:0] mem_m [16];
  int         exp_acc;
  int         vectors;
  int         miscompares;

  sram_responder_16x8 #(.ADDR_W(4), .DATA_W(8), .READ_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .ce_n(ce_n), .we_n(we_n), .oe_n(oe_n),
    .addr(addr), .wdata(wdata), .rdata(rd1), .rdata_valid(v1),
    .busy(b1), .err(e1), .acc_cnt(ac1)
  );

  sram_responder_16x8 #(.ADDR_W(4), .DATA_W(8), .READ_LAT(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .ce_n(ce_n), .we_n(we_n), .oe_n(oe_n),
    .addr(addr), .wdata(wdata), .rdata(rd3), .rdata_valid(v3),
    .busy(b3), .err(e3), .acc_cnt(ac3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    ce_n = 1'b1;
    we_n = 1'b1;
    oe_n = 1'b1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
    exp_acc = 0;
  endtask

  task automatic do_reset();
    bus_idle();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    model_clear();
    cyc();
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = a; wdata = d;
    cyc();
    bus_idle();
    cyc();
    mem_m[a] = d;
    exp_acc = (exp_acc + 1) % 256;
  endtask

  task automatic hold_read(input logic [3:0] a, input int n);
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; addr = a;
    repeat (n) cyc();
  endtask

  task automatic test_reset();
    logic [3:0] a;
    bus_idle();
    addr = 4'h0; wdata = 8'h00;
    rst_n = 1'b0;
    repeat (2) cyc();
    vectors++;
    if ({rd1, v1, b1, e1, ac1, rd3, v3, b3, e3, ac3} !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_hold: got l1 rd=%h v=%b b=%b e=%b acc=%h l3 rd=%h v=%b b=%b e=%b acc=%h, want all 0",
               rd1, v1, b1, e1, ac1, rd3, v3, b3, e3, ac3);
    end
    rst_n = 1'b1;
    model_clear();
    cyc();
    vectors++;
    if ({rd1, v1, b1, e1, ac1, rd3, v3, b3, e3, ac3} !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_release: got l1 v=%b b=%b acc=%h l3 v=%b b=%b acc=%h, want all 0",
               v1, b1, ac1, v3, b3, ac3);
    end
    a = 4'($urandom_range(15));
    hold_read(a, 5);
    vectors++;
    if (v1 !== 1'b1 || rd1 !== 8'h00 || v3 !== 1'b1 || rd3 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_read a=%0d: got l1 v=%b d=%h l3 v=%b d=%h, want v=1 d=00", a, v1, rd1, v3, rd3);
    end
    bus_idle();
    cyc();
  endtask

  task automatic test_write_read();
    logic [3:0] a, ra;
    logic [7:0] d, x1, x3;
    logic       ev1, ev3;
    do_reset();
    for (int it = 0; it < 10; it++) begin
      a  = (it == 0) ? 4'd5 : 4'($urandom_range(15));
      d  = (it == 0) ? 8'hAA : 8'($urandom);
      ra = (it % 3 == 2) ? 4'($urandom_range(15)) : a;
      do_write(a, d);
      hold_read(ra, 0);
      for (int e = 1; e <= 5; e++) begin
        cyc();
        ev1 = (e >= 2);
        ev3 = (e >= 4);
        x1  = ev1 ? mem_m[ra] : 8'h00;
        x3  = ev3 ? mem_m[ra] : 8'h00;
        vectors++;
        if (v1 !== ev1 || rd1 !== x1) begin
          miscompares++;
          $display("FAIL wr_rd_l1 it=%0d edge=%0d: got v=%b d=%h, want v=%b d=%h", it, e, v1, rd1, ev1, x1);
        end
        vectors++;
        if (v3 !== ev3 || rd3 !== x3) begin
          miscompares++;
          $display("FAIL wr_rd_l3 it=%0d edge=%0d: got v=%b d=%h, want v=%b d=%h", it, e, v3, rd3, ev3, x3);
        end
      end
      exp_acc = (exp_acc + 1) % 256;
      bus_idle();
      cyc();
      vectors++;
      if (ac1 !== 8'(exp_acc) || ac3 !== 8'(exp_acc) || v1 !== 1'b0 || rd1 !== 8'h00 ||
          v3 !== 1'b0 || rd3 !== 8'h00 || b1 !== 1'b0 || b3 !== 1'b0) begin
        miscompares++;
        $display("FAIL wr_rd_release it=%0d: got acc %0d/%0d v=%b/%b busy=%b/%b, want acc %0d v=0 busy=0",
                 it, ac1, ac3, v1, v3, b1, b3, exp_acc);
      end
    end
  endtask

  task automatic test_data_last_wins();
    logic ev3;
    do_reset();
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = 4'd3; wdata = 8'h11;
    cyc();
    vectors++;
    if (b1 !== 1'b1 || b3 !== 1'b1) begin
      miscompares++;
      $display("FAIL write_busy: got %b/%b, want 1", b1, b3);
    end
    wdata = 8'h22;
    cyc();
    wdata = 8'h33;
    cyc();
    bus_idle();
    cyc();
    mem_m[3] = 8'h33;
    exp_acc  = 1;
    vectors++;
    if (ac1 !== 8'd1 || ac3 !== 8'd1 || b1 !== 1'b0 || b3 !== 1'b0) begin
      miscompares++;
      $display("FAIL write_commit: got acc %0d/%0d busy %b/%b, want acc 1 busy 0", ac1, ac3, b1, b3);
    end
    hold_read(4'd3, 0);
    for (int e = 1; e <= 5; e++) begin
      cyc();
      ev3 = (e >= 4);
      vectors++;
      if (v3 !== ev3 || rd3 !== (ev3 ? 8'h33 : 8'h00)) begin
        miscompares++;
        $display("FAIL last_wins_l3 edge=%0d: got v=%b d=%h, want v=%b d=%h", e, v3, rd3, ev3, ev3 ? 8'h33 : 8'h00);
      end
    end
    vectors++;
    if (v1 !== 1'b1 || rd1 !== 8'h33) begin
      miscompares++;
      $display("FAIL last_wins_l1: got v=%b d=%h, want v=1 d=33", v1, rd1);
    end
    bus_idle();
    cyc();
  endtask

  task automatic test_abort_addr_change();
    logic [7:0] d5, x1, x3;
    logic       ev1, ev3;
    do_reset();
    d5 = 8'($urandom);
    do_write(4'd5, d5);
    do_write(4'd3, 8'h33);
    hold_read(4'd5, 1);
    oe_n = 1'b1;
    cyc();
    vectors++;
    if (v1 !== 1'b0 || v3 !== 1'b0 || b1 !== 1'b0 || b3 !== 1'b0 ||
        ac1 !== 8'(exp_acc) || ac3 !== 8'(exp_acc)) begin
      miscompares++;
      $display("FAIL read_abort: got v=%b/%b busy=%b/%b acc=%0d/%0d, want v=0 busy=0 acc=%0d",
               v1, v3, b1, b3, ac1, ac3, exp_acc);
    end
    bus_idle();
    cyc();
    hold_read(4'd5, 5);
    exp_acc = (exp_acc + 1) % 256;
    vectors++;
    if (v1 !== 1'b1 || rd1 !== d5 || v3 !== 1'b1 || rd3 !== d5) begin
      miscompares++;
      $display("FAIL drive_addr5: got v=%b/%b d=%h/%h, want v=1 d=%h", v1, v3, rd1, rd3, d5);
    end
    addr = 4'd3;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      ev1 = (k >= 2);
      ev3 = (k >= 4);
      x1  = ev1 ? 8'h33 : 8'h00;
      x3  = ev3 ? 8'h33 : 8'h00;
      vectors++;
      if (v1 !== ev1 || rd1 !== x1 || v3 !== ev3 || rd3 !== x3) begin
        miscompares++;
        $display("FAIL addr_change edge=%0d: got v=%b/%b d=%h/%h, want v=%b/%b d=%h/%h",
                 k, v1, v3, rd1, rd3, ev1, ev3, x1, x3);
      end
    end
    exp_acc = (exp_acc + 1) % 256;
    bus_idle();
    cyc();
    vectors++;
    if (ac1 !== 8'(exp_acc) || ac3 !== 8'(exp_acc)) begin
      miscompares++;
      $display("FAIL addr_change_acc: got %0d/%0d, want %0d", ac1, ac3, exp_acc);
    end
  endtask

  task automatic test_protocol_error();
    logic [3:0] wa;
    do_reset();
    for (int i = 0; i < 4; i++) do_write(4'($urandom_range(15)), 8'($urandom));
    wa = 4'($urandom_range(15));
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0; addr = wa; wdata = ~mem_m[wa];
    cyc();
    vectors++;
    if (e1 !== 1'b1 || e3 !== 1'b1 || b1 !== 1'b1 || b3 !== 1'b1 || v1 !== 1'b0 || v3 !== 1'b0) begin
      miscompares++;
      $display("FAIL conflict_enter: got err=%b/%b busy=%b/%b v=%b/%b, want err=1 busy=1 v=0",
               e1, e3, b1, b3, v1, v3);
    end
    we_n = 1'b1;
    repeat (2) cyc();
    vectors++;
    if (b1 !== 1'b1 || b3 !== 1'b1) begin
      miscompares++;
      $display("FAIL error_hold: got busy=%b/%b, want 1", b1, b3);
    end
    bus_idle();
    cyc();
    vectors++;
    if (b1 !== 1'b0 || b3 !== 1'b0 || e1 !== 1'b1 || e3 !== 1'b1) begin
      miscompares++;
      $display("FAIL error_exit: got busy=%b/%b err=%b/%b, want busy=0 err=1", b1, b3, e1, e3);
    end
    // Output enable asserted in the middle of a write must discard it.
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = wa; wdata = ~mem_m[wa];
    cyc();
    oe_n = 1'b0;
    cyc();
    vectors++;
    if (b1 !== 1'b1 || b3 !== 1'b1 || e1 !== 1'b1 || e3 !== 1'b1) begin
      miscompares++;
      $display("FAIL write_conflict: got busy=%b/%b err=%b/%b, want 1", b1, b3, e1, e3);
    end
    bus_idle();
    cyc();
    vectors++;
    if (ac1 !== 8'(exp_acc) || ac3 !== 8'(exp_acc)) begin
      miscompares++;
      $display("FAIL error_no_commit_acc: got %0d/%0d, want %0d", ac1, ac3, exp_acc);
    end
    hold_read(wa, 5);
    exp_acc = (exp_acc + 1) % 256;
    vectors++;
    if (v1 !== 1'b1 || rd1 !== mem_m[wa] || v3 !== 1'b1 || rd3 !== mem_m[wa]) begin
      miscompares++;
      $display("FAIL error_mem_unchanged a=%0d: got v=%b/%b d=%h/%h, want v=1 d=%h",
               wa, v1, v3, rd1, rd3, mem_m[wa]);
    end
    we_n = 1'b0;
    cyc();
    vectors++;
    if (v1 !== 1'b0 || rd1 !== 8'h00 || v3 !== 1'b0 || rd3 !== 8'h00 || b1 !== 1'b1 || b3 !== 1'b1) begin
      miscompares++;
      $display("FAIL drive_we_error: got v=%b/%b d=%h/%h busy=%b/%b, want v=0 d=00 busy=1",
               v1, v3, rd1, rd3, b1, b3);
    end
    bus_idle();
    cyc();
    do_reset();
    vectors++;
    if (e1 !== 1'b0 || e3 !== 1'b0) begin
      miscompares++;
      $display("FAIL err_cleared_by_reset: got %b/%b, want 0", e1, e3);
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    do_write(4'($urandom_range(15)), 8'($urandom));
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = 4'd7; wdata = 8'h5A;
    cyc();
    vectors++;
    if (b1 !== 1'b1 || b3 !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_write_busy: got %b/%b, want 1", b1, b3);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (b1 !== 1'b0 || b3 !== 1'b0 || ac1 !== 8'h00 || ac3 !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset: got busy=%b/%b acc=%0d/%0d, want busy=0 acc=0", b1, b3, ac1, ac3);
    end
    bus_idle();
    model_clear();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    hold_read(4'd7, 5);
    vectors++;
    if (v1 !== 1'b1 || rd1 !== 8'h00 || v3 !== 1'b1 || rd3 !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_write_no_commit: got v=%b/%b d=%h/%h, want v=1 d=00", v1, v3, rd1, rd3);
    end
    bus_idle();
    cyc();
  endtask

  task automatic test_acc_wrap();
    logic [3:0] a;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      do_write(4'($urandom_range(15)), 8'($urandom));
      if (i == 254) begin
        vectors++;
        if (ac1 !== 8'd255 || ac3 !== 8'd255) begin
          miscompares++;
          $display("FAIL acc_255: got %0d/%0d, want 255", ac1, ac3);
        end
      end
    end
    vectors++;
    if (ac1 !== 8'd0 || ac3 !== 8'd0 || exp_acc != 0) begin
      miscompares++;
      $display("FAIL acc_wrap: got %0d/%0d, want 0", ac1, ac3);
    end
    for (int i = 0; i < 4; i++) begin
      a = 4'($urandom_range(15));
      hold_read(a, 5);
      exp_acc = (exp_acc + 1) % 256;
      vectors++;
      if (rd1 !== mem_m[a] || rd3 !== mem_m[a] || v1 !== 1'b1 || v3 !== 1'b1) begin
        miscompares++;
        $display("FAIL wrap_readback a=%0d: got d=%h/%h v=%b/%b, want d=%h v=1", a, rd1, rd3, v1, v3, mem_m[a]);
      end
      bus_idle();
      cyc();
    end
    vectors++;
    if (ac1 !== 8'(exp_acc) || ac3 !== 8'(exp_acc)) begin
      miscompares++;
      $display("FAIL wrap_final_acc: got %0d/%0d, want %0d", ac1, ac3, exp_acc);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_acc     = 0;
    rst_n       = 1'b0;
    addr        = 4'h0;
    wdata       = 8'h00;
    bus_idle();
    test_reset();
    test_write_read();
    test_data_last_wins();
    test_abort_addr_change();
    test_protocol_error();
    test_reset_mid_write();
    test_acc_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_responder_16x8.md
Name: sram_responder_16x8

Overview:
Cycle-accurate 16x8 SRAM device model that sits on the far side of the memory controller's active-low strobe interface (ce_n/we_n/oe_n, addr, data). It stores write data, returns read data after a programmable latency, and flags illegal strobe combinations. It is the responder counterpart used to close the loop on controller benches and integrates as the on-chip SRAM behind the controller.

Parameters:
ADDR_W, 4, address width; depth = 2**ADDR_W = 16
DATA_W, 8, data width
READ_LAT, 1, clock edges from first sampled read strobe to rdata_valid; legal range 1..4

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
ce_n  input  1  chip enable, active low
we_n  input  1  write enable, active low
oe_n  input  1  output enable, active low
addr  input  ADDR_W  word address
wdata  input  DATA_W  write data from controller
rdata  output  DATA_W  read data; 0 whenever rdata_valid=0
rdata_valid  output  1  rdata holds mem[addr] of the current read
busy  output  1  high in any state other than IDLE
err  output  1  sticky protocol-violation flag
acc_cnt  output  8  count of completed accesses (writes committed + reads delivered)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all 16 memory words=0, rdata=0, rdata_valid=0, busy=0, err=0, acc_cnt=0. Reset mid-access aborts it; no memory update.
- Single clock; all strobes sampled on the rising edge of clk, registered outputs only.
- States: IDLE, WRITE, READ_WAIT, READ_DRIVE, ERROR.
- IDLE:
  - ce_n=0, we_n=0, oe_n=1: go to WRITE; latch addr into addr_q and wdata into wdata_q.
  - ce_n=0, oe_n=0, we_n=1: go to READ_WAIT; latch addr_q; load cnt=READ_LAT-1.
  - ce_n=0, we_n=0, oe_n=0: go to ERROR; set err=1.
  - Otherwise (ce_n=1, or ce_n=0 with both strobes high): stay in IDLE.
- WRITE:
  - While ce_n=0 and we_n=0, re-latch wdata_q every cycle. The last sampled data wins.
  - addr_q is fixed at entry.
  - If oe_n=0 is sampled while we_n=0: go to ERROR, set err=1, no commit.
  - On the first edge sampling ce_n=1 or we_n=1 (trailing edge): write mem[addr_q]<=wdata_q, increment acc_cnt, go to IDLE. The write is visible to a read that starts on the next edge.
- READ_WAIT:
  - If ce_n=1 or oe_n=1 is sampled: abort and go to IDLE; rdata_valid stays 0; acc_cnt unchanged.
  - If we_n=0 is sampled: go to ERROR.
  - Else if cnt=0: go to READ_DRIVE, set rdata=mem[addr_q], rdata_valid=1, increment acc_cnt.
  - Else decrement cnt.
  - Net effect: rdata_valid rises exactly READ_LAT edges after the edge that first sampled the read strobe.
- READ_DRIVE:
  - Holds rdata and rdata_valid=1 while ce_n=0, oe_n=0, we_n=1, and addr==addr_q.
  - If addr changes: treat as a new read. Drop rdata_valid and set rdata=0, latch the new addr, reload cnt, go to READ_WAIT.
  - If strobes are released: rdata=0, rdata_valid=0, go to IDLE.
  - If we_n=0 is sampled: go to ERROR.
- ERROR:
  - rdata=0, rdata_valid=0, no memory writes.
  - Stay until ce_n=1 is sampled, then go to IDLE.
  - err stays 1 until reset.
- acc_cnt is 8-bit and wraps 255->0.
- Addresses are always in range (no out-of-range case at 16 deep).

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> all outputs 0, busy=0. Read any address after release -> 0x00.
- Write then read, READ_LAT=1: ce_n=0, we_n=0, addr=5, wdata=0xAA for 1 cycle, then release. Then ce_n=0, oe_n=0, addr=5 -> rdata=0xAA with rdata_valid=1 one edge after the strobe is sampled; acc_cnt=2.
- Data-wins-last and latency 3: hold the write to addr=3 for 3 cycles with wdata 0x11, 0x22, 0x33 -> mem[3]=0x33. With READ_LAT=3, rdata_valid rises on the 3rd edge after the read strobe.
- Read abort and address change: release oe_n during READ_WAIT (READ_LAT=3) -> no valid, acc_cnt unchanged. In READ_DRIVE at addr 5, change addr to 3 -> valid drops, then returns with 0x33 after READ_LAT edges.
- Protocol error: ce_n=0, we_n=0, oe_n=0 -> err=1, busy=1, memory unchanged. ce_n=1 -> IDLE with err still 1. Only rst_n clears err.
- Reset mid-write: assert rst_n=0 while in WRITE to addr 7 with wdata 0x5A -> mem[7]=0, state IDLE. Also run 256 single-cycle writes -> acc_cnt wraps to 0.
